// File: rtl/dfe_train_ctrl.sv
// rtl/dfe_train_ctrl.sv - DFE input pacing and sign-sign LMS h1 training sequencer
module dfe_train_ctrl #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int TAP_WIDTH         = 4,
    parameter int TAP_INIT          = 1,
    parameter int TRAIN_LEN         = 64,
    parameter int DEC_TIMEOUT       = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                retrain,
    input  logic signed [SIGNAL_RESOLUTION-1:0] sample_in,
    input  logic                                sample_in_valid,
    output logic                                sample_in_ready,
    input  logic signed [SIGNAL_RESOLUTION-1:0] train_data,
    input  logic                                train_data_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] dfe_in,
    output logic                                dfe_in_valid,
    input  logic signed [SIGNAL_RESOLUTION-1:0] dec_in,
    input  logic                                dec_valid,
    output logic signed [TAP_WIDTH-1:0]         tap_h1,
    output logic                                tap_update,
    output logic [1:0]                          mode,
    output logic                                train_done,
    output logic                                timeout_err
);

    localparam int SR  = SIGNAL_RESOLUTION;
    localparam int TW  = TAP_WIDTH;
    localparam int GW  = $clog2(SYMBOL_SEPERATION + 1);
    localparam int TMW = $clog2(DEC_TIMEOUT + 1);
    localparam int CW  = $clog2(TRAIN_LEN + 1);

    localparam logic [GW-1:0]  GAP_RELOAD = GW'(SYMBOL_SEPERATION - 1);
    localparam logic [TMW-1:0] TMO_LAST   = TMW'(DEC_TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(TRAIN_LEN - 1);
    localparam logic [TW-1:0]  TAP_RST    = TW'(TAP_INIT);
    localparam logic [TW-1:0]  TAP_MAX    = {1'b0, {(TW-1){1'b1}}};
    localparam logic [TW-1:0]  TAP_MIN    = {1'b1, {(TW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tap_q, tap_d;
    logic [SR-1:0]  prev_dec_q, prev_dec_d;
    logic [SR-1:0]  exp_sym_q, exp_sym_d;
    logic [SR-1:0]  dfe_in_q, dfe_in_d;
    logic           dfe_in_valid_q, dfe_in_valid_d;
    logic           tap_update_q, tap_update_d;
    logic           pending_q, pending_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TMW-1:0] tmo_q, tmo_d;
    logic [CW-1:0]  train_cnt_q, train_cnt_d;
    logic           train_done_q, train_done_d;
    logic           timeout_err_q, timeout_err_d;
    logic           retrain_pend_q, retrain_pend_d;

    logic              ready;
    logic              accept;
    logic              dec_take;
    logic signed [SR:0] err_s;
    logic signed [1:0]  delta;
    logic signed [TW:0] tap_sum;
    logic [TW-1:0]      tap_next;

    // A retrain request in DATA blocks new issues so the hand-over happens on a clean symbol boundary.
    assign ready = ((state_q == S_TRAIN) || (state_q == S_DATA)) && !pending_q &&
                   (gap_q == '0) && !retrain_pend_q && !((state_q == S_DATA) && retrain);
    assign accept   = sample_in_valid && ready && ((state_q != S_TRAIN) || train_data_valid);
    assign dec_take = dec_valid && pending_q;

    assign err_s = $signed({exp_sym_q[SR-1], exp_sym_q}) - $signed({dec_in[SR-1], dec_in});

    always_comb begin
        delta = 2'sd0;
        if (err_s != '0) begin
            delta = (err_s[SR] ^ prev_dec_q[SR-1]) ? -2'sd1 : 2'sd1;
        end
        tap_sum  = $signed({tap_q[TW-1], tap_q}) + $signed({{(TW-1){delta[1]}}, delta});
        tap_next = tap_sum[TW-1:0];
        if (tap_sum[TW] != tap_sum[TW-1]) begin
            tap_next = tap_sum[TW] ? TAP_MIN : TAP_MAX;
        end
    end

    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        prev_dec_d     = prev_dec_q;
        exp_sym_d      = exp_sym_q;
        dfe_in_d       = dfe_in_q;
        dfe_in_valid_d = 1'b0;
        pending_d      = pending_q;
        gap_d          = gap_q;
        tmo_d          = tmo_q;
        train_cnt_d    = train_cnt_q;
        train_done_d   = train_done_q;
        timeout_err_d  = timeout_err_q;
        retrain_pend_d = retrain_pend_q;

        if (gap_q != '0) gap_d = gap_q - GW'(1);
        if (pending_q) tmo_d = tmo_q + TMW'(1);

        if (accept) begin
            dfe_in_d       = sample_in;
            dfe_in_valid_d = 1'b1;
            pending_d      = 1'b1;
            gap_d          = GAP_RELOAD;
            tmo_d          = '0;
            if (state_q == S_TRAIN) exp_sym_d = train_data;
        end

        if (dec_take) begin
            pending_d  = 1'b0;
            tmo_d      = '0;
            prev_dec_d = dec_in;
            if (state_q == S_TRAIN) begin
                tap_d       = tap_next;
                train_cnt_d = train_cnt_q + CW'(1);
                if (train_cnt_q == CNT_LAST) begin
                    state_d      = S_DATA;
                    train_done_d = 1'b1;
                end
            end
        end else if (pending_q && (tmo_q == TMO_LAST)) begin
            timeout_err_d  = 1'b1;
            pending_d      = 1'b0;
            tmo_d          = '0;
            retrain_pend_d = 1'b0;
            state_d        = S_IDLE;
        end

        if ((state_q == S_IDLE && start) ||
            (state_q == S_DATA && state_d == S_DATA && (retrain || retrain_pend_q) &&
             !(pending_q && !dec_take))) begin
            state_d        = S_TRAIN;
            train_cnt_d    = '0;
            prev_dec_d     = '0;
            train_done_d   = 1'b0;
            timeout_err_d  = 1'b0;
            retrain_pend_d = 1'b0;
            tap_d          = TAP_RST;
        end else if (state_q == S_DATA && state_d == S_DATA && retrain) begin
            retrain_pend_d = 1'b1;
        end

        tap_update_d = (tap_d != tap_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tap_q          <= TAP_RST;
            prev_dec_q     <= '0;
            exp_sym_q      <= '0;
            dfe_in_q       <= '0;
            dfe_in_valid_q <= 1'b0;
            tap_update_q   <= 1'b0;
            pending_q      <= 1'b0;
            gap_q          <= '0;
            tmo_q          <= '0;
            train_cnt_q    <= '0;
            train_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            retrain_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            prev_dec_q     <= prev_dec_d;
            exp_sym_q      <= exp_sym_d;
            dfe_in_q       <= dfe_in_d;
            dfe_in_valid_q <= dfe_in_valid_d;
            tap_update_q   <= tap_update_d;
            pending_q      <= pending_d;
            gap_q          <= gap_d;
            tmo_q          <= tmo_d;
            train_cnt_q    <= train_cnt_d;
            train_done_q   <= train_done_d;
            timeout_err_q  <= timeout_err_d;
            retrain_pend_q <= retrain_pend_d;
        end
    end

    assign sample_in_ready = ready;
    assign dfe_in          = dfe_in_q;
    assign dfe_in_valid    = dfe_in_valid_q;
    assign tap_h1          = tap_q;
    assign tap_update      = tap_update_q;
    assign mode            = state_q;
    assign train_done      = train_done_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_dfe_train_ctrl.sv
// tb/tb_dfe_train_ctrl.sv - directed bench for dfe_train_ctrl (default and short-training instances)
module tb_dfe_train_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, sel;
    logic start, retrain, sample_in_valid, train_data_valid, dec_valid;
    logic signed [7:0] sample_in, train_data, dec_in;

    logic              a_ready, a_dfe_valid, a_upd, a_done, a_tmo;
    logic signed [7:0] a_dfe_in;
    logic signed [3:0] a_tap;
    logic [1:0]        a_mode;
    logic              b_ready, b_dfe_valid, b_upd, b_done, b_tmo;
    logic signed [7:0] b_dfe_in;
    logic signed [3:0] b_tap;
    logic [1:0]        b_mode;

    dfe_train_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .start(start), .retrain(retrain),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(a_ready),
        .train_data(train_data), .train_data_valid(train_data_valid),
        .dfe_in(a_dfe_in), .dfe_in_valid(a_dfe_valid),
        .dec_in(dec_in), .dec_valid(dec_valid),
        .tap_h1(a_tap), .tap_update(a_upd), .mode(a_mode),
        .train_done(a_done), .timeout_err(a_tmo)
    );

    dfe_train_ctrl #(.SYMBOL_SEPERATION(4), .TRAIN_LEN(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start), .retrain(retrain),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(b_ready),
        .train_data(train_data), .train_data_valid(train_data_valid),
        .dfe_in(b_dfe_in), .dfe_in_valid(b_dfe_valid),
        .dec_in(dec_in), .dec_valid(dec_valid),
        .tap_h1(b_tap), .tap_update(b_upd), .mode(b_mode),
        .train_done(b_done), .timeout_err(b_tmo)
    );

    logic              o_ready, o_dfe_valid, o_upd, o_done, o_tmo;
    logic signed [7:0] o_dfe_in;
    logic signed [3:0] o_tap;
    logic [1:0]        o_mode;
    assign o_ready     = sel ? b_ready     : a_ready;
    assign o_dfe_valid = sel ? b_dfe_valid : a_dfe_valid;
    assign o_upd       = sel ? b_upd       : a_upd;
    assign o_done      = sel ? b_done      : a_done;
    assign o_tmo       = sel ? b_tmo       : a_tmo;
    assign o_dfe_in    = sel ? b_dfe_in    : a_dfe_in;
    assign o_tap       = sel ? b_tap       : a_tap;
    assign o_mode      = sel ? b_mode      : a_mode;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 300) begin
            tick();
            n++;
        end
        check_eq("ready_wait", int'(o_ready), 1);
    endtask

    task automatic do_symbol(input int smp, input int td, input int tdv, input int dec, output int upd);
        wait_ready();
        sample_in        = smp[7:0];
        train_data       = td[7:0];
        train_data_valid = tdv[0];
        sample_in_valid  = 1'b1;
        tick();
        sample_in_valid  = 1'b0;
        train_data_valid = 1'b0;
        check_eq("issue_valid", int'(o_dfe_valid), 1);
        check_eq("issue_data", int'(o_dfe_in), smp);
        tick();
        tick();
        dec_in    = dec[7:0];
        dec_valid = 1'b1;
        tick();
        dec_valid = 1'b0;
        upd = int'(o_upd);
    endtask

    task automatic check_reset_state();
        check_eq("rst_mode", int'(o_mode), 0);
        check_eq("rst_ready", int'(o_ready), 0);
        check_eq("rst_tap", int'(o_tap), 1);
        check_eq("rst_done", int'(o_done), 0);
        check_eq("rst_tmo", int'(o_tmo), 0);
        check_eq("rst_dfe_valid", int'(o_dfe_valid), 0);
        check_eq("rst_upd", int'(o_upd), 0);
    endtask

    int t3_td  [13] = '{64, 64, 64, 64, 64, 64, 64, 64, -64, 5,   0, 100, -128};
    int t3_dec [13] = '{32, 32, 32, 32, 32, 32, 32, 32,  32, 5, -10,  50,  127};
    int t3_tap [13] = '{ 2,  3,  4,  5,  6,  7,  7,  7,   6, 6,   7,   6,    5};
    int t3_upd [13] = '{ 1,  1,  1,  1,  1,  1,  0,  0,   1, 0,   1,   1,    1};

    initial begin
        #500000;
        $display("FAIL watchdog got running expected finished");
        $fatal(1);
    end

    initial begin
        int upd, last, npulse, drv, seen;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        start = 1'b0; retrain = 1'b0; sample_in_valid = 1'b0; train_data_valid = 1'b0;
        dec_valid = 1'b0; sample_in = '0; train_data = '0; dec_in = '0;
        tick(); tick();
        rst_a = 1'b0;
        tick();
        check_reset_state();

        // pacing: samples offered every cycle, decisions 3 cycles after issue
        pulse_start();
        check_eq("start_mode", int'(o_mode), 1);
        sample_in_valid = 1'b1; train_data_valid = 1'b1; train_data = 8'sd64; dec_in = 8'sd32;
        drv = 0; sample_in = '0; last = -1; npulse = 0;
        for (int cyc = 0; cyc < 180; cyc++) begin
            tick();
            if (o_dfe_valid) begin
                if (last >= 0) check_eq("issue_spacing", cyc - last, 56);
                check_eq("paced_data", int'(o_dfe_in), drv);
                last = cyc;
                npulse++;
            end
            dec_valid = (last >= 0) && (cyc == last + 2);
            drv = (cyc * 13) % 120 - 60;
            sample_in = drv[7:0];
        end
        check_eq("issue_count", npulse, 4);
        sample_in_valid = 1'b0; train_data_valid = 1'b0; dec_valid = 1'b0;

        // decision timeout
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        pulse_start();
        sample_in = 8'sd9; sample_in_valid = 1'b1; train_data_valid = 1'b1;
        tick();
        check_eq("tmo_issue", int'(o_dfe_valid), 1);
        seen = 0;
        repeat (254) begin
            tick();
            if (o_ready) seen = 1;
        end
        check_eq("tmo_early_err", int'(o_tmo), 0);
        check_eq("tmo_early_mode", int'(o_mode), 1);
        tick();
        check_eq("tmo_err", int'(o_tmo), 1);
        check_eq("tmo_mode", int'(o_mode), 0);
        check_eq("tmo_tap_held", int'(o_tap), 1);
        check_eq("tmo_no_ready", seen, 0);
        sample_in_valid = 1'b0; train_data_valid = 1'b0;
        pulse_start();
        check_eq("tmo_cleared", int'(o_tmo), 0);
        check_eq("tmo_restart_mode", int'(o_mode), 1);

        // sign-sign LMS steps, saturation at +7, zero error, sign combinations
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            do_symbol(i * 11 - 60, t3_td[i], 1, t3_dec[i], upd);
            check_eq($sformatf("lms_tap_%0d", i), int'(o_tap), t3_tap[i]);
            check_eq($sformatf("lms_upd_%0d", i), upd, t3_upd[i]);
        end
        check_eq("lms_still_train", int'(o_mode), 1);

        // short-training instance
        rst_a = 1'b1; sel = 1'b1;
        rst_b = 1'b1; start = 1'b1; tick(); start = 1'b0;
        check_eq("rst_beats_start", int'(o_mode), 0);
        rst_b = 1'b0;
        tick();
        check_reset_state();
        pulse_start();
        sample_in_valid = 1'b1; train_data_valid = 1'b0; seen = 0;
        repeat (3) begin
            tick();
            if (o_dfe_valid) seen = 1;
        end
        check_eq("train_needs_tdv", seen, 0);
        sample_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_symbol(10 + i, 64, 1, 32, upd);
            check_eq($sformatf("tl_tap_%0d", i), int'(o_tap), 2 + i);
            check_eq($sformatf("tl_mode_%0d", i), int'(o_mode), (i == 3) ? 2 : 1);
            check_eq($sformatf("tl_done_%0d", i), int'(o_done), (i == 3) ? 1 : 0);
        end
        do_symbol(-20, -64, 0, 32, upd);
        check_eq("data_tap_frozen1", int'(o_tap), 5);
        check_eq("data_upd1", upd, 0);
        do_symbol(21, 64, 0, -100, upd);
        check_eq("data_tap_frozen2", int'(o_tap), 5);
        check_eq("data_upd2", upd, 0);
        pulse_start();
        check_eq("start_ignored_data", int'(o_mode), 2);

        // retrain while a decision is outstanding
        wait_ready();
        sample_in = 8'sd33; sample_in_valid = 1'b1;
        tick();
        sample_in_valid = 1'b0;
        retrain = 1'b1; tick(); retrain = 1'b0;
        check_eq("retrain_held_mode", int'(o_mode), 2);
        check_eq("retrain_held_ready", int'(o_ready), 0);
        tick(); tick(); tick();
        check_eq("retrain_wait_mode", int'(o_mode), 2);
        check_eq("retrain_wait_done", int'(o_done), 1);
        dec_in = -8'sd50; dec_valid = 1'b1; tick(); dec_valid = 1'b0;
        check_eq("retrain_mode", int'(o_mode), 1);
        check_eq("retrain_tap", int'(o_tap), 1);
        check_eq("retrain_done", int'(o_done), 0);
        dec_valid = 1'b1; tick(); dec_valid = 1'b0;
        check_eq("stray_dec_tap", int'(o_tap), 1);
        check_eq("stray_dec_upd", int'(o_upd), 0);
        do_symbol(5, -64, 1, 32, upd);
        check_eq("prev_dec_cleared_tap", int'(o_tap), 0);
        for (int i = 0; i < 3; i++) begin
            do_symbol(i, 64, 1, 32, upd);
            check_eq($sformatf("rt_tap_%0d", i), int'(o_tap), 1 + i);
        end
        check_eq("rt_data_mode", int'(o_mode), 2);

        // retrain and a would-be accept in the same cycle
        wait_ready();
        sample_in_valid = 1'b1; retrain = 1'b1;
        #1;
        check_eq("retrain_blocks_ready", int'(o_ready), 0);
        tick();
        sample_in_valid = 1'b0; retrain = 1'b0;
        check_eq("retrain_no_issue", int'(o_dfe_valid), 0);
        check_eq("retrain_now_mode", int'(o_mode), 1);
        check_eq("retrain_now_tap", int'(o_tap), 1);

        // reset with a decision outstanding
        wait_ready();
        sample_in_valid = 1'b1; train_data_valid = 1'b1;
        tick();
        sample_in_valid = 1'b0; train_data_valid = 1'b0;
        check_eq("mid_issue", int'(o_dfe_valid), 1);
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        check_eq("mid_rst_mode", int'(o_mode), 0);
        check_eq("mid_rst_ready", int'(o_ready), 0);
        pulse_start();
        check_eq("mid_rst_pending_dropped", int'(o_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
